// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential step, stall, and redirect with a one-deep
// holding slot so a redirect seen during a stall is applied when fetch resumes.
module pc_sequencer #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              INC          = 4,
   parameter int              ALIGN_BITS   = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            PC_En,
   input  logic            Redirect_En,
   input  logic [XLEN-1:0] Redirect_Target,
   output logic [XLEN-1:0] PC_Out,
   output logic [XLEN-1:0] PC_Plus_Inc,
   output logic            Redirect_Pending,
   output logic            Misaligned
);

   localparam logic [XLEN-1:0] INC_V    = XLEN'(INC);
   localparam logic [XLEN-1:0] LOW_MASK = ~({XLEN{1'b1}} << ALIGN_BITS);

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pending_target_q, pending_target_d;
   logic            misaligned_q, misaligned_d;
   logic [XLEN-1:0] aligned_target;

   // Redirect_Target is only consumed under Redirect_En, so X on it stays out of state.
   assign aligned_target = Redirect_Target & ~LOW_MASK;

   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      pending_target_d = pending_target_q;
      misaligned_d     = 1'b0;

      if (Redirect_En) begin
         misaligned_d = |(Redirect_Target & LOW_MASK);
      end

      if (state_q == RUN) begin
         if (PC_En) begin
            if (Redirect_En) begin
               pc_d = aligned_target;
            end else begin
               pc_d = pc_q + INC_V;
            end
         end else if (Redirect_En) begin
            pending_target_d = aligned_target;
            state_d          = HOLD;
         end
      end else begin
         if (PC_En) begin
            // A live redirect is younger than the held one, so it wins.
            if (Redirect_En) begin
               pc_d = aligned_target;
            end else begin
               pc_d = pending_target_q;
            end
            state_d = RUN;
         end else if (Redirect_En) begin
            pending_target_d = aligned_target;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q          <= RUN;
         pc_q             <= RESET_VECTOR;
         pending_target_q <= '0;
         misaligned_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         pending_target_q <= pending_target_d;
         misaligned_q     <= misaligned_d;
      end
   end

   assign PC_Out           = pc_q;
   assign PC_Plus_Inc      = pc_q + INC_V;
   assign Redirect_Pending = (state_q == HOLD);
   assign Misaligned       = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default parameters plus an ALIGN_BITS=1, INC=2 variant.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_en;
   logic        redirect_en;
   logic [31:0] redirect_target;

   logic [31:0] a_pc, a_plus;
   logic        a_pend, a_mis;
   logic [31:0] b_pc, b_plus;
   logic        b_pend, b_mis;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_sequencer dut_a (
      .CLK              (clk),
      .RST              (rst),
      .PC_En            (pc_en),
      .Redirect_En      (redirect_en),
      .Redirect_Target  (redirect_target),
      .PC_Out           (a_pc),
      .PC_Plus_Inc      (a_plus),
      .Redirect_Pending (a_pend),
      .Misaligned       (a_mis)
   );

   pc_sequencer #(.INC(2), .ALIGN_BITS(1)) dut_b (
      .CLK              (clk),
      .RST              (rst),
      .PC_En            (pc_en),
      .Redirect_En      (redirect_en),
      .Redirect_Target  (redirect_target),
      .PC_Out           (b_pc),
      .PC_Plus_Inc      (b_plus),
      .Redirect_Pending (b_pend),
      .Misaligned       (b_mis)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs, take one rising edge, then settle before sampling.
   task automatic step(input logic r, input logic en, input logic ren, input logic [31:0] tgt);
      rst             = r;
      pc_en           = en;
      redirect_en     = ren;
      redirect_target = tgt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with an X target and no redirect: nothing may pick up X.
      step(1'b1, 1'b0, 1'b0, 'x);
      chk("reset_pc", a_pc, 32'h0);
      chk("reset_plus", a_plus, 32'h4);
      chk("reset_pend", a_pend, 0);
      chk("reset_mis", a_mis, 0);

      step(1'b0, 1'b1, 1'b0, 'x);
      chk("inc1_pc", a_pc, 32'h4);
      chk("inc1_plus", a_plus, 32'h8);
      step(1'b0, 1'b1, 1'b0, 'x);
      chk("inc2_pc", a_pc, 32'h8);
      step(1'b0, 1'b1, 1'b0, 'x);
      chk("inc3_pc", a_pc, 32'hC);
      chk("inc3_plus", a_plus, 32'h10);

      // Wrap-around
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
      chk("wrap_redir_pc", a_pc, 32'hFFFF_FFF8);
      chk("wrap_redir_mis", a_mis, 0);
      step(1'b0, 1'b1, 1'b0, 'x);
      chk("wrap_top_pc", a_pc, 32'hFFFF_FFFC);
      chk("wrap_top_plus", a_plus, 32'h0);
      step(1'b0, 1'b1, 1'b0, 'x);
      chk("wrap_zero_pc", a_pc, 32'h0);
      chk("wrap_zero_plus", a_plus, 32'h4);

      // Stalled redirect, newest wins
      step(1'b0, 1'b1, 1'b1, 32'h100);
      chk("stall_base_pc", a_pc, 32'h100);
      step(1'b0, 1'b0, 1'b1, 32'h200);
      chk("stall_cap1_pc", a_pc, 32'h100);
      chk("stall_cap1_pend", a_pend, 1);
      step(1'b0, 1'b0, 1'b1, 32'h300);
      chk("stall_cap2_pc", a_pc, 32'h100);
      chk("stall_cap2_pend", a_pend, 1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 'x);
         chk("stall_hold_pc", a_pc, 32'h100);
         chk("stall_hold_pend", a_pend, 1);
      end
      step(1'b0, 1'b1, 1'b0, 'x);
      chk("stall_apply_pc", a_pc, 32'h300);
      chk("stall_apply_pend", a_pend, 0);
      step(1'b0, 1'b1, 1'b0, 'x);
      chk("stall_next_pc", a_pc, 32'h304);

      // Live redirect beats pending one
      step(1'b0, 1'b0, 1'b1, 32'h400);
      chk("live_cap_pend", a_pend, 1);
      chk("live_cap_pc", a_pc, 32'h304);
      step(1'b0, 1'b1, 1'b1, 32'h500);
      chk("live_apply_pc", a_pc, 32'h500);
      chk("live_apply_pend", a_pend, 0);
      step(1'b0, 1'b1, 1'b0, 'x);
      chk("live_next_pc", a_pc, 32'h504);

      // Misalignment, both parameter sets
      step(1'b0, 1'b1, 1'b1, 32'h1003);
      chk("mis_pc", a_pc, 32'h1000);
      chk("mis_pulse", a_mis, 1);
      chk("mis_b_pc", b_pc, 32'h1002);
      chk("mis_b_plus", b_plus, 32'h1004);
      chk("mis_b_pulse", b_mis, 1);
      step(1'b0, 1'b1, 1'b0, 'x);
      chk("mis_drop", a_mis, 0);
      chk("mis_after_pc", a_pc, 32'h1004);
      chk("mis_b_after_pc", b_pc, 32'h1004);
      step(1'b0, 1'b1, 1'b1, 32'h2000);
      chk("aligned_pc", a_pc, 32'h2000);
      chk("aligned_mis", a_mis, 0);
      step(1'b0, 1'b0, 1'b1, 32'h2001);
      chk("mis_stall_pulse", a_mis, 1);
      chk("mis_stall_pc", a_pc, 32'h2000);
      chk("mis_b_stall_pend", b_pend, 1);

      // Reset mid-HOLD discards the pending target
      step(1'b0, 1'b0, 1'b1, 32'h800);
      chk("rst_hold_pend", a_pend, 1);
      chk("rst_hold_mis", a_mis, 0);
      step(1'b1, 1'b1, 1'b0, 'x);
      chk("rst_mid_pc", a_pc, 32'h0);
      chk("rst_mid_pend", a_pend, 0);
      step(1'b0, 1'b1, 1'b0, 'x);
      chk("rst_release_pc", a_pc, 32'h4);
      chk("rst_release_pend", a_pend, 0);
      chk("rst_b_release_pc", b_pc, 32'h2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
